// File: rtl/seq_slice_comparator_pkg.sv
// Shared types for the sequential slice comparator: FSM state encoding and
// the helper that sizes the slice index register.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single slice still needs a one-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_slice_comparator_if.sv
// Operand/result bundle of the sequential slice comparator.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1;
// the producer holds valid and its payload until that edge, and ready never waits on valid.
interface seq_slice_comparator_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_ip;
  logic [WIDTH-1:0] b_ip;
  logic             signed_ip;
  logic             a_ip_G;
  logic             b_ip_G;
  logic             a_ip_E_b;
  logic             out_valid;
  logic             out_ready;
  logic             a_op_G;
  logic             b_op_G;
  logic             a_op_E_b;

  modport master (
    output in_valid, a_ip, b_ip, signed_ip, a_ip_G, b_ip_G, a_ip_E_b, out_ready,
    input  in_ready, out_valid, a_op_G, b_op_G, a_op_E_b
  );

  modport slave (
    input  in_valid, a_ip, b_ip, signed_ip, a_ip_G, b_ip_G, a_ip_E_b, out_ready,
    output in_ready, out_valid, a_op_G, b_op_G, a_op_E_b
  );
endinterface

// File: rtl/seq_slice_comparator_slice_cmp.sv
// Combinational unsigned magnitude compare of one SLICE-bit slice.
module slice_cmp #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);
  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);
endmodule

// File: rtl/seq_slice_comparator.sv
// Multi-cycle MSB-first magnitude comparator: one SLICE-bit slice per cycle,
// optional early exit, 74LS85-style cascade inputs and valid/ready on both sides.
module seq_slice_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int SLICE      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_slice_comparator_if.slave  bus,
  output state_t                 state_dbg
);
  localparam int NSLICE = (SLICE > 0) ? WIDTH / SLICE : 1;
  localparam int IW     = idx_width(NSLICE);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
    $error("seq_slice_comparator: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx_q;
  logic             cas_a_gt_q, cas_b_gt_q, cas_eq_q;
  logic             decided_q, dec_a_gt_q, dec_b_gt_q;
  logic             out_valid_q, res_a_gt_q, res_b_gt_q, res_eq_q;
  logic [SLICE-1:0] a_slice, b_slice;
  logic             slice_gt, slice_lt, slice_eq;
  logic             take, now_decided, finish;
  logic [2:0]       final_res;

  always_comb begin
    a_slice = a_q[int'(idx_q)*SLICE +: SLICE];
    b_slice = b_q[int'(idx_q)*SLICE +: SLICE];
  end

  slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
    .a  (a_slice),
    .b  (b_slice),
    .gt (slice_gt),
    .lt (slice_lt),
    .eq (slice_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    take        = bus.in_valid && (state_q == IDLE);
    now_decided = decided_q || !slice_eq;
    finish      = ((EARLY_EXIT != 0) && now_decided) || (idx_q == '0);
    case (state_q)
      IDLE:    if (take) state_d = CMP;
      CMP:     if (finish) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A frozen decision wins; otherwise this slice; all-equal falls to the cascade.
  always_comb begin
    final_res = 3'b000;
    if (decided_q)             final_res = {dec_a_gt_q, dec_b_gt_q, 1'b0};
    else if (!slice_eq)        final_res = {slice_gt, slice_lt, 1'b0};
    else if (cas_eq_q)         final_res = 3'b001;
    else                       final_res = {cas_a_gt_q, cas_b_gt_q, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= IW'(NSLICE - 1);
      cas_a_gt_q  <= 1'b0;
      cas_b_gt_q  <= 1'b0;
      cas_eq_q    <= 1'b0;
      decided_q   <= 1'b0;
      dec_a_gt_q  <= 1'b0;
      dec_b_gt_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_a_gt_q  <= 1'b0;
      res_b_gt_q  <= 1'b0;
      res_eq_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (take) begin
          // Offset-binary: flipping the sign bit makes signed order match unsigned order.
          a_q        <= bus.a_ip ^ (bus.signed_ip ? MSB_MASK : '0);
          b_q        <= bus.b_ip ^ (bus.signed_ip ? MSB_MASK : '0);
          idx_q      <= IW'(NSLICE - 1);
          cas_a_gt_q <= bus.a_ip_G;
          cas_b_gt_q <= bus.b_ip_G;
          cas_eq_q   <= bus.a_ip_E_b;
          decided_q  <= 1'b0;
        end
        CMP: begin
          if (!decided_q && !slice_eq) begin
            decided_q  <= 1'b1;
            dec_a_gt_q <= slice_gt;
            dec_b_gt_q <= slice_lt;
          end
          if (finish) begin
            out_valid_q <= 1'b1;
            {res_a_gt_q, res_b_gt_q, res_eq_q} <= final_res;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: if (bus.out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.a_op_G    = res_a_gt_q;
  assign bus.b_op_G    = res_b_gt_q;
  assign bus.a_op_E_b  = res_eq_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_seq_slice_comparator.sv
// Bench for seq_slice_comparator: an early-exit and a constant-latency instance
// receive identical stimulus and are checked against an arithmetic reference model.
module tb_seq_slice_comparator;
  import cmp_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  seq_slice_comparator_if #(.WIDTH(W)) if_e ();
  seq_slice_comparator_if #(.WIDTH(W)) if_c ();
  state_t st_e, st_c;

  seq_slice_comparator #(.WIDTH(W), .SLICE(4), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(if_e), .state_dbg(st_e)
  );
  seq_slice_comparator #(.WIDTH(W), .SLICE(4), .EARLY_EXIT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c), .state_dbg(st_c)
  );

  // ---------------- driver tasks ----------------
  task automatic drive_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic cg, input logic cl, input logic ce);
    if_e.a_ip = a; if_e.b_ip = b; if_e.signed_ip = s;
    if_e.a_ip_G = cg; if_e.b_ip_G = cl; if_e.a_ip_E_b = ce;
    if_c.a_ip = a; if_c.b_ip = b; if_c.signed_ip = s;
    if_c.a_ip_G = cg; if_c.b_ip_G = cl; if_c.a_ip_E_b = ce;
  endtask

  task automatic set_ctl(input logic iv, input logic ordy);
    if_e.in_valid = iv; if_e.out_ready = ordy;
    if_c.in_valid = iv; if_c.out_ready = ordy;
  endtask

  task automatic scramble_ops();
    drive_ops(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // ---------------- reference model ----------------
  function automatic int exp_lat_early(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = 3; i >= 0; i--)
      if (a[i*4 +: 4] != b[i*4 +: 4]) return 4 - i;
    return 4;
  endfunction

  function automatic logic [2:0] exp_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic cg, input logic cl,
                                         input logic ce);
    int va, vb;
    va = s ? int'($signed(a)) : int'(a);
    vb = s ? int'($signed(b)) : int'(b);
    if (va > vb) return 3'b100;
    if (va < vb) return 3'b010;
    if (ce)      return 3'b001;
    return {cg, cl, 1'b0};
  endfunction

  function automatic logic [2:0] res_of(input int d);
    return (d == 0) ? {if_e.a_op_G, if_e.b_op_G, if_e.a_op_E_b}
                    : {if_c.a_op_G, if_c.b_op_G, if_c.a_op_E_b};
  endfunction

  // ---------------- scenarios ----------------
  task automatic run_txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic cg, input logic cl, input logic ce);
    logic [2:0] er;
    logic [2:0] r;
    logic       ov;
    int         el[2];
    int         lat[2];
    @(negedge clk);
    drive_ops(a, b, s, cg, cl, ce);
    set_ctl(1'b1, 1'b1);
    n_cmp++;
    if (if_e.in_ready !== 1'b1 || if_c.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s in_ready got %b/%b want 1/1", name, if_e.in_ready, if_c.in_ready);
    end
    @(posedge clk); #1;
    set_ctl(1'b0, 1'b1);
    scramble_ops();
    er = exp_res(a, b, s, cg, cl, ce);
    el[0] = exp_lat_early(a, b);
    el[1] = 4;
    lat[0] = 0; lat[1] = 0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        ov = (d == 0) ? if_e.out_valid : if_c.out_valid;
        r  = res_of(d);
        if (lat[d] == 0 && ov === 1'b1) begin
          lat[d] = k;
          n_cmp++;
          if (r !== er) begin
            n_bad++;
            $display("FAIL %s dut%0d result got %b want %b", name, d, r, er);
          end
        end else if (lat[d] != 0) begin
          n_cmp++;
          if (ov !== 1'b0) begin
            n_bad++;
            $display("FAIL %s dut%0d out_valid after take got %b want 0", name, d, ov);
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (lat[d] != el[d]) begin
        n_bad++;
        $display("FAIL %s dut%0d latency got %0d want %0d (0 = timeout)", name, d, lat[d], el[d]);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({if_e.out_valid, res_of(0), if_c.out_valid, res_of(1)} !== 8'h00 ||
        if_e.in_ready !== 1'b0 || st_e !== IDLE || st_c !== IDLE) begin
      n_bad++;
      $display("FAIL reset_state got ov=%b res=%b in_ready=%b want 0/000/0",
               if_e.out_valid, res_of(0), if_e.in_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (if_e.in_ready !== 1'b1 || if_c.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release in_ready got %b/%b want 1/1", if_e.in_ready, if_c.in_ready);
    end
  endtask

  task automatic test_directed();
    run_txn("unsigned_msb", 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("signed_msb",   16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("signed_neg1",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    run_txn("cascade_eq",   16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    run_txn("cascade_agt",  16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
    run_txn("cascade_both", 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0);
    run_txn("first_slice",  16'h9235, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    run_txn("last_slice",   16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive_ops(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ctl(1'b1, 1'b0);
    @(posedge clk); #1;
    set_ctl(1'b0, 1'b0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive_ops(16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
      set_ctl(1'b1, 1'b0);
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (if_e.out_valid !== 1'b1 || if_c.out_valid !== 1'b1 ||
          if_e.in_ready !== 1'b0 || if_c.in_ready !== 1'b0 ||
          res_of(0) !== 3'b100 || res_of(1) !== 3'b100) begin
        n_bad++;
        $display("FAIL backpressure_hold cyc%0d got ov=%b%b rdy=%b%b res=%b/%b want 11 00 100/100",
                 k, if_e.out_valid, if_c.out_valid, if_e.in_ready, if_c.in_ready,
                 res_of(0), res_of(1));
      end
    end
    set_ctl(1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    n_cmp++;
    if (if_e.out_valid !== 1'b0 || if_c.out_valid !== 1'b0 ||
        if_e.in_ready !== 1'b1 || if_c.in_ready !== 1'b1 ||
        res_of(0) !== 3'b100 || res_of(1) !== 3'b100) begin
      n_bad++;
      $display("FAIL backpressure_release got ov=%b%b rdy=%b%b res=%b/%b want 00 11 100/100",
               if_e.out_valid, if_c.out_valid, if_e.in_ready, if_c.in_ready,
               res_of(0), res_of(1));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_ops(16'h1235, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ctl(1'b1, 1'b1);
    @(posedge clk); #1;
    set_ctl(1'b0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({if_e.out_valid, res_of(0), if_c.out_valid, res_of(1)} !== 8'h00 ||
        st_e !== IDLE || st_c !== IDLE) begin
      n_bad++;
      $display("FAIL reset_mid got ov=%b%b res=%b/%b want 00 000/000",
               if_e.out_valid, if_c.out_valid, res_of(0), res_of(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (if_e.in_ready !== 1'b1 || if_c.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_release in_ready got %b/%b want 1/1", if_e.in_ready, if_c.in_ready);
    end
    run_txn("post_reset", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int n = 0; n < 60; n++) begin
      a = 16'($urandom);
      b = a;
      if ($urandom_range(0, 4) == 0) b = 16'($urandom);
      else
        for (int i = 0; i < 4; i++)
          if ($urandom_range(0, 3) == 0) b[i*4 +: 4] = 4'($urandom_range(0, 15));
      run_txn("random", a, b, 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 2) == 0));
    end
  endtask

  initial begin
    drive_ops('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_ctl(1'b0, 1'b0);
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_slice_comparator.md
Name: seq_slice_comparator

Overview:
Parametrised multi-cycle magnitude comparator. It succeeds the fixed 4/8-bit combinational comparators with configurable width and a signed/unsigned mode. Operands are compared MSB-first, one SLICE-bit slice per cycle, with optional early termination and 74LS85-style cascade inputs. A valid/ready handshake sits on both input and output, so it drops into pipelined datapaths that need wide compares without a long combinational path.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of SLICE.
SLICE, 4, bits compared per cycle; SLICE == WIDTH gives a single compare cycle.
EARLY_EXIT, 1, 1 = finish on the first unequal slice; 0 = always run all NSLICE = WIDTH/SLICE cycles (constant latency).

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands and mode are valid.
in_ready  output  1  block can accept operands; high only in IDLE.
a_ip  input  WIDTH  operand A.
b_ip  input  WIDTH  operand B.
signed_ip  input  1  1 = two's-complement compare; 0 = unsigned.
a_ip_G  input  1  cascade in: lower stage has A>B.
b_ip_G  input  1  cascade in: lower stage has B>A.
a_ip_E_b  input  1  cascade in: lower stage has A==B.
out_valid  output  1  result valid; held until it is taken.
out_ready  input  1  consumer takes the result.
a_op_G  output  1  A>B.
b_op_G  output  1  B>A.
a_op_E_b  output  1  A==B.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; out_valid, a_op_G, b_op_G, a_op_E_b = 0; slice index = NSLICE-1. in_ready=1 whenever rst_n=1 and the state is IDLE.
- Accept: on in_valid & in_ready at a rising edge, register a_ip, b_ip, signed_ip and the three cascade inputs, then go to CMP. In signed mode, invert bit WIDTH-1 of both registered operands (offset-binary), so signed and unsigned modes share one unsigned slice compare.
- CMP: each cycle, compare slice idx (bits idx*SLICE+SLICE-1 : idx*SLICE) of A and B, starting at idx=NSLICE-1.
  - If the slices differ, latch a_op_G/b_op_G from that slice and set decided=1.
  - If decided and EARLY_EXIT=1, or if idx==0, go to DONE.
  - Otherwise decrement idx.
  - With EARLY_EXIT=0, a decided result is frozen; later slices do not alter it.
- Cascade: if all slices are equal, the result comes from the latched cascade inputs. a_ip_E_b=1 forces a_op_E_b=1 and both G outputs to 0. Otherwise a_op_G=a_ip_G and b_op_G=b_ip_G, with a_op_E_b=0, passed through even if both are 1.
- Latency, measured from the accept edge to out_valid=1:
  - EARLY_EXIT=0: NSLICE cycles.
  - EARLY_EXIT=1: (NSLICE - index of first differing slice) cycles, min 1, max NSLICE.
- DONE: out_valid=1. Results are stable and in_ready=0 until out_valid & out_ready. At that edge, go to IDLE, set out_valid=0, and leave result outputs holding their last value. No same-cycle re-accept: back-to-back throughput is one compare per latency+2 cycles.
- In-flight inputs: in_valid while not in IDLE is ignored. Changes on a_ip/b_ip/signed_ip/cascade inputs after accept have no effect.
- Exactly one of the three result outputs is 1 whenever out_valid=1, except for cascade pass-through of inconsistent G inputs.
- Reset mid-CMP or mid-DONE: immediate return to reset values; the pending result is discarded.
- Elaboration check: if WIDTH % SLICE != 0 or SLICE < 1, stop elaboration with an error.

Decomposition:
- Package cmp_pkg: state enum {IDLE, CMP, DONE} and the function clog2-based index width for NSLICE.
- Sub-module slice_cmp (combinational, SLICE-bit unsigned compare giving gt/lt/eq). It is instantiated once and muxed by idx. The FSM, operand registers, sign fix-up and cascade resolution live in seq_slice_comparator.

Test Plan:
1. WIDTH=16, SLICE=4, EARLY_EXIT=1, signed=0, a=0x8000, b=0x7FFF -> out_valid 1 cycle after accept; a_op_G=1, b_op_G=0, a_op_E_b=0.
2. Same operands with signed=1 -> out_valid after 1 cycle; b_op_G=1 (-32768 < 32767). Also a=0xFFFF, b=0x0000, signed=1 -> b_op_G=1 after 1 cycle.
3. a=b=0x1234 with cascade {a_ip_G=0, b_ip_G=0, a_ip_E_b=1} -> a_op_E_b=1 after 4 cycles. Repeat with {1,0,0} -> a_op_G=1 after 4 cycles.
4. EARLY_EXIT=0, a=0x9235, b=0x1234 -> out_valid exactly 4 cycles after accept; a_op_G=1 (first slice decides, result frozen). EARLY_EXIT=1, same operands -> 1 cycle. a=0x1235, b=0x1234 -> 4 cycles, a_op_G=1.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with new operands -> outputs stable, in_ready=0, new operands not taken. Then out_ready=1 -> IDLE next cycle, in_ready=1.
6. Assert rst_n=0 in the 2nd CMP cycle -> out_valid and results 0 immediately (no clock needed); after release in_ready=1, and the next compare a=0x0001, b=0x0002 -> b_op_G=1.
